// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low rows, debounces a single pressed key,
// latches its code onto A..D and holds E while the key stays down.
module keypad_scanner #(
  parameter int SCAN_DIV     = 10000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] COL,
  output logic [3:0] ROW,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       KEY_STROBE,
  output logic [1:0] DBG_STATE
);

  // Handshake: none. E is a level "key available" flag; KEY_STROBE is a
  // single-cycle pulse on the cycle E rises; A..D are valid whenever E is high
  // and keep the last code after E falls.

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DB_MAX    = 8'(DEBOUNCE_CNT);

  state_t      state_q;
  logic [3:0]  col_meta_q;
  logic [3:0]  col_sync_q;
  logic [15:0] tick_cnt_q;
  logic [1:0]  row_q;
  logic [1:0]  key_col_q;
  logic [7:0]  db_cnt_q;
  logic [3:0]  code_q;
  logic        e_q;
  logic        strobe_q;

  logic        tick;
  logic        single_low;
  logic [1:0]  low_idx;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    single_low = 1'b0;
    low_idx    = 2'd0;
    case (col_sync_q)
      4'b1110: begin single_low = 1'b1; low_idx = 2'd0; end
      4'b1101: begin single_low = 1'b1; low_idx = 2'd1; end
      4'b1011: begin single_low = 1'b1; low_idx = 2'd2; end
      4'b0111: begin single_low = 1'b1; low_idx = 2'd3; end
      default: begin single_low = 1'b0; low_idx = 2'd0; end
    endcase
  end

  // Idle value of the column lines is all-ones (pulled up), so the synchronizer resets high.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
      tick_cnt_q <= 16'd0;
    end else begin
      col_meta_q <= COL;
      col_sync_q <= col_meta_q;
      tick_cnt_q <= tick ? 16'd0 : tick_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      key_col_q <= 2'd0;
      db_cnt_q  <= 8'd0;
      code_q    <= 4'd0;
      e_q       <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (tick) begin
        case (state_q)
          SCAN: begin
            if (single_low) begin
              key_col_q <= low_idx;
              db_cnt_q  <= 8'd0;
              state_q   <= DEBOUNCE;
            end else begin
              row_q <= row_q + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (single_low && (low_idx == key_col_q)) begin
              // Counter stops at DB_MAX; it is cleared again on the next entry.
              if (db_cnt_q >= DB_MAX - 8'd1) begin
                db_cnt_q <= DB_MAX;
                code_q   <= {row_q, key_col_q};
                e_q      <= 1'b1;
                strobe_q <= 1'b1;
                state_q  <= HELD;
              end else begin
                db_cnt_q <= db_cnt_q + 8'd1;
              end
            end else begin
              state_q <= SCAN;
              row_q   <= row_q + 2'd1;
            end
          end
          HELD: begin
            if (col_sync_q == 4'hF) begin
              db_cnt_q <= 8'd0;
              state_q  <= RELEASE;
            end
          end
          RELEASE: begin
            if (col_sync_q == 4'hF) begin
              if (db_cnt_q >= DB_MAX - 8'd1) begin
                db_cnt_q <= DB_MAX;
                e_q      <= 1'b0;
                state_q  <= SCAN;
                row_q    <= row_q + 2'd1;
              end else begin
                db_cnt_q <= db_cnt_q + 8'd1;
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

  assign ROW        = ~(4'b0001 << row_q);
  assign {D, C, B, A} = code_q;
  assign E          = e_q;
  assign KEY_STROBE = strobe_q;
  assign DBG_STATE  = state_q;

endmodule
